// File: rtl/regfile_write_scheduler.sv
// Register-file write scheduler: issue scoreboard plus round-robin arbitration of ALU/load writebacks.
// Optional macro REGFILE_CLEAR_EN zeroes x1..x31 after reset release before accepting traffic.
module regfile_write_scheduler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1_ptr,
    input  logic [4:0]  rs2_ptr,
    output logic        hazard,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        rf_write_en,
    output logic [4:0]  rf_write_ptr,
    output logic [31:0] rf_write_data,
    output logic [31:0] busy_mask,
    output logic        init_done
);

    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_t;

    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] busy_q, busy_d;
    logic [31:0] set_vec, clr_vec;
    logic        issue_accept;

`ifdef REGFILE_CLEAR_EN
    logic init_done_q, init_done_d;
    assign init_done = init_done_q;
`else
    assign init_done = 1'b1;
`endif

    // busy_q[0] never sets, so looking up x0 always reads "not busy"
    assign hazard       = !init_done || busy_q[rs1_ptr] || busy_q[rs2_ptr] || busy_q[issue_rd];
    assign issue_accept = issue_valid && !hazard;

    assign set_vec = (issue_accept && issue_rd != 5'd0) ? (32'd1 << issue_rd) : 32'd0;
    assign clr_vec = wr_en_q ? (32'd1 << wr_ptr_q) : 32'd0;

    // Set has priority so a re-issue at the write edge keeps the register busy
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_busy
            assign busy_d[gi] = set_vec[gi] | (busy_q[gi] & ~clr_vec[gi]);
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        wr_data_d    = wr_data_q;
        alu_ready    = 1'b0;
        mem_ready    = 1'b0;
`ifdef REGFILE_CLEAR_EN
        init_done_d  = init_done_q;
`endif
        case (state_q)
            ST_RESET: begin
`ifdef REGFILE_CLEAR_EN
                state_d   = ST_CLEAR;
                wr_en_d   = 1'b1;
                wr_ptr_d  = 5'd1;
                wr_data_d = 32'd0;
`else
                state_d   = ST_RUN;
`endif
            end
            ST_CLEAR: begin
`ifdef REGFILE_CLEAR_EN
                if (wr_ptr_q == 5'd31) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 5'd1;
                    wr_data_d = 32'd0;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                alu_ready = alu_valid && (!mem_valid || last_grant_q == GRANT_MEM);
                mem_ready = mem_valid && (!alu_valid || last_grant_q == GRANT_ALU);
                if (alu_ready) begin
                    last_grant_d = GRANT_ALU;
                    wr_en_d      = (alu_rd != 5'd0);
                    wr_ptr_d     = alu_rd;
                    wr_data_d    = alu_data;
                end else if (mem_ready) begin
                    last_grant_d = GRANT_MEM;
                    wr_en_d      = (mem_rd != 5'd0);
                    wr_ptr_d     = mem_rd;
                    wr_data_d    = mem_data;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RESET;
            last_grant_q <= GRANT_MEM;
            wr_en_q      <= 1'b0;
            wr_ptr_q     <= 5'd0;
            wr_data_q    <= 32'd0;
            busy_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
        end
    end

`ifdef REGFILE_CLEAR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= init_done_d;
        end
    end
`endif

    assign rf_write_en   = wr_en_q;
    assign rf_write_ptr  = wr_ptr_q;
    assign rf_write_data = wr_data_q;
    assign busy_mask     = busy_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench: stimulus pushes expected writes into a queue; a monitor pops and compares them.
module tb_regfile_write_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0, rs1_ptr = '0, rs2_ptr = '0;
    logic        hazard;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_rd = '0, mem_rd = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready;
    logic        rf_write_en;
    logic [4:0]  rf_write_ptr;
    logic [31:0] rf_write_data;
    logic [31:0] busy_mask;
    logic        init_done;

    regfile_write_scheduler dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_ptr(rs1_ptr), .rs2_ptr(rs2_ptr), .hazard(hazard),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_write_en(rf_write_en), .rf_write_ptr(rf_write_ptr), .rf_write_data(rf_write_data),
        .busy_mask(busy_mask), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [4:0]  ptr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int compared = 0;
    int mismatched = 0;

    // Reference model: set of busy registers, who won last, and the write due to land this cycle
    logic [31:0] m_busy = '0;
    logic        m_init = 1'b0;
    logic        m_last_mem = 1'b1;
    logic        pend_v = 1'b0;
    logic [4:0]  pend_rd = '0;

`ifdef REGFILE_CLEAR_EN
    localparam logic INIT_IN_RESET = 1'b0;
`else
    localparam logic INIT_IN_RESET = 1'b1;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                w = exp_q.pop_front();
                compared++;
                mismatched++;
                $display("FAIL write_missing: got none expected ptr %0d data %h at cycle %0d", w.ptr, w.data, w.c);
            end
            if (rf_write_en) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL write_unexpected: got ptr %0d data %h expected no write (cycle %0d)", rf_write_ptr, rf_write_data, cyc);
                end else begin
                    w = exp_q.pop_front();
                    chk("write_cycle", 32'(cyc), 32'(w.c));
                    chk("write_ptr", 32'(rf_write_ptr), 32'(w.ptr));
                    chk("write_data", rf_write_data, w.data);
                    $display("write cycle %0d ptr %0d data %h", cyc, rf_write_ptr, rf_write_data);
                end
            end
        end
    end

    task automatic step(input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        logic eh, ear, emr;
        @(negedge clk);
        issue_valid = iv; issue_rd = ird; rs1_ptr = r1; rs2_ptr = r2;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        #1;
        eh  = !m_init || (r1 != 0 && m_busy[r1]) || (r2 != 0 && m_busy[r2]) || (ird != 0 && m_busy[ird]);
        ear = m_init && av && (!mv || m_last_mem);
        emr = m_init && mv && (!av || !m_last_mem);
        chk("hazard", 32'(hazard), 32'(eh));
        chk("alu_ready", 32'(alu_ready), 32'(ear));
        chk("mem_ready", 32'(mem_ready), 32'(emr));
        chk("busy_mask", busy_mask, m_busy);
        chk("init_done", 32'(init_done), 32'(m_init));
        if (pend_v) m_busy[pend_rd] = 1'b0;
        if (iv && !eh && ird != 0) m_busy[ird] = 1'b1;
        pend_v = 1'b0;
        if (ear) begin
            m_last_mem = 1'b0;
            if (ard != 0) begin
                pend_v = 1'b1; pend_rd = ard;
                exp_q.push_back('{c: cyc + 1, ptr: ard, data: ad});
            end
        end else if (emr) begin
            m_last_mem = 1'b1;
            if (mrd != 0) begin
                pend_v = 1'b1; pend_rd = mrd;
                exp_q.push_back('{c: cyc + 1, ptr: mrd, data: md});
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        reset_n = 1'b0;
        issue_valid = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        exp_q.delete();
        m_busy = '0; pend_v = 1'b0; m_last_mem = 1'b1; m_init = INIT_IN_RESET;
        chk("rst_write_en", 32'(rf_write_en), 32'd0);
        chk("rst_write_ptr", 32'(rf_write_ptr), 32'd0);
        chk("rst_write_data", rf_write_data, 32'd0);
        chk("rst_busy_mask", busy_mask, 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'(INIT_IN_RESET));
        $display("reset asserted at cycle %0d", cyc);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        $display("reset released at cycle %0d", cyc);
`ifdef REGFILE_CLEAR_EN
        m_init = 1'b0;
        for (int i = 1; i <= 31; i++) exp_q.push_back('{c: cyc + i, ptr: 5'(i), data: 32'd0});
        repeat (31) idle();
`endif
        m_init = 1'b1;
    endtask

    initial begin
        assert_reset();
        release_reset();

        // Contention: ALU wins first, MEM second
        step(0, 0, 0, 0, 1, 5, 32'hAAAA0001, 1, 6, 32'hBBBB0002);
        step(0, 0, 0, 0, 1, 5, 32'hAAAA0001, 1, 6, 32'hBBBB0002);
        idle(); idle();

        // Scoreboard set, RAW hazard, and clear two cycles after the load transfer
        step(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 8, 7, 0, 0, 0, 0, 0, 0, 0);
        chk("busy_after_issue7", busy_mask, 32'h0000_0080);
        step(0, 0, 7, 0, 0, 0, 0, 1, 7, 32'h1234_5678);
        step(0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        chk("hazard_after_wb", 32'(hazard), 32'd0);
        chk("busy_after_wb", busy_mask, 32'd0);

        // WAW block, x0 issue and x0 writeback
        step(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("waw_busy", busy_mask, 32'h0000_0080);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0);
        idle();
        step(0, 0, 0, 0, 1, 7, 32'h0000_0777, 0, 0, 0);
        idle(); idle();

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end
        idle(); idle();

        // Reset in the cycle the write to x9 would be presented
        step(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 9, 32'h9999_0009, 0, 0, 0);
        assert_reset();
        release_reset();
        idle(); idle(); idle();

        for (int i = 0; i < 100; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end
        idle(); idle(); idle();

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL pending_writes: got %0d outstanding expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
